ntram_core: RTL

NTRAM_CORE -- requirements
Module: ntram_core

---
 rtl/ntram_pkg.sv | 40 ++++
 rtl/ntram_array.sv | 33 +++
 rtl/ntram_core.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ntram_pkg.sv
// Shared types and helpers for the NtRAM core: operation codes, the
// pipeline-stage record and the burst address sequencing functions.
package ntram_pkg;

  typedef enum logic [1:0] {
    DESEL = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } op_t;

  // Stage fields are sized for the widest supported configuration; the
  // core uses only the low ADDR_W address bits and BYTES lane bits.
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_BYTES  = 8;

  typedef logic [MAX_ADDR_W-1:0] addr_t;
  typedef logic [MAX_BYTES-1:0]  lane_t;

  typedef struct packed {
    op_t   op;
    addr_t addr;
    lane_t bw_n;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{op: DESEL, addr: '0, bw_n: '0};

  // Low burst address bits: linear (base + count) or interleaved (base ^ count).
  // For a 2-beat burst only bit 0 is used, so the carry into bit 1 is harmless.
  function automatic logic [1:0] burst_low(input logic [1:0] base,
                                           input logic [1:0] cnt,
                                           input logic       lbo_b);
    return lbo_b ? (base ^ cnt) : (base + cnt);
  endfunction

  // Next beat count, wrapping after BURST beats.
  function automatic logic [1:0] burst_next(input logic [1:0] cnt, input int burst);
    return (burst == 2) ? {1'b0, ~cnt[0]} : (cnt + 2'd1);
  endfunction

endpackage

// File: rtl/ntram_array.sv
// Storage array: synchronous per-lane write, one synchronous read port,
// read-before-write on a same-address collision, no reset.
module ntram_array
  import ntram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int BYTES  = 2,
  parameter int BYTE_W = 9,
  parameter int DW     = BYTES * BYTE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BYTES-1:0]  wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [0:(2**ADDR_W)-1];

  // Lane-masked write and registered read; the read sees pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wen[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntram_core.sv
// NtRAM (no-turnaround) synchronous SRAM core with 2-cycle read/write
// pipeline, linear/interleaved bursts, clock-enable stall and sleep.
//
// Output qualifier: rd_valid is high for exactly the cycles whose Dq_o
// carries a read beat; Dq_oe = rd_valid & ~OEb & ~ZZ. Stalled or sleeping
// edges hold both Dq_o and rd_valid.
module ntram_core
  import ntram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int BYTES  = 2,
  parameter int BYTE_W = 9,
  parameter int BURST  = 4
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic [ADDR_W-1:0]         Addr,
  input  logic                      WEb,
  input  logic [BYTES-1:0]          Bw_n,
  input  logic                      CKEb,
  input  logic                      CS1b,
  input  logic                      CS2,
  input  logic                      CS2b,
  input  logic                      ADV,
  input  logic                      LBOb,
  input  logic                      OEb,
  input  logic                      ZZ,
  input  logic [BYTES*BYTE_W-1:0]   Dq_i,
  output logic [BYTES*BYTE_W-1:0]   Dq_o,
  output logic                      Dq_oe
);

  localparam int DW = BYTES * BYTE_W;
  localparam int LW = (BURST == 4) ? 2 : 1;

  logic              en;
  op_t               prev_op, cmd_op;
  logic [ADDR_W-1:0] base, nxt_base, beat_addr;
  logic [1:0]        cnt, nxt_cnt, low;
  logic [BYTES-1:0]  bw_lat, nxt_bw;
  stage_t            s1, s2, beat;
  logic              wb_valid, rd_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DW-1:0]     wb_data, rdata, merged;
  logic [BYTES-1:0]  wb_lane, wr_lane;
  logic              wr_en;
  logic              unused_hi;

  assign en        = ~CKEb & ~ZZ;
  assign wr_en     = en & RSTb & (s2.op == WRITE);
  assign wr_lane   = ~s2.bw_n[BYTES-1:0];
  assign Dq_oe     = rd_valid & ~OEb & ~ZZ;
  assign unused_hi = ^{s2.addr, s2.bw_n};

  // Command decode and burst sequencing for the beat issued this cycle.
  always_comb begin
    cmd_op    = prev_op;
    nxt_base  = base;
    nxt_cnt   = cnt;
    nxt_bw    = bw_lat;
    beat_addr = base;
    low       = '0;
    if (!ADV) begin
      if (CS1b || !CS2 || CS2b) cmd_op = DESEL;
      else if (!WEb)            cmd_op = WRITE;
      else                      cmd_op = READ;
      nxt_base  = Addr;
      nxt_cnt   = 2'd0;
      nxt_bw    = Bw_n;
      beat_addr = Addr;
    end else begin
      nxt_cnt = burst_next(cnt, BURST);
      low     = burst_low(base[1:0], nxt_cnt, LBOb);
      beat_addr[LW-1:0] = low[LW-1:0];
      if (prev_op == WRITE) nxt_bw = Bw_n;
    end
    beat.op   = cmd_op;
    beat.addr = addr_t'(beat_addr);
    beat.bw_n = lane_t'(nxt_bw);
  end

  // Read data: array output with the write committed one cycle earlier
  // merged over it, since the array read saw the pre-write contents.
  always_comb begin
    merged = rdata;
    if (wb_valid && (wb_addr == s2.addr[ADDR_W-1:0])) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wb_lane[i]) merged[i*BYTE_W +: BYTE_W] = wb_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Burst state, pipeline stages, bypass record and read output registers.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      prev_op  <= DESEL;
      base     <= '0;
      cnt      <= 2'd0;
      bw_lat   <= '0;
      s1       <= STAGE_IDLE;
      s2       <= STAGE_IDLE;
      wb_valid <= 1'b0;
      rd_valid <= 1'b0;
      Dq_o     <= '0;
    end else if (en) begin
      prev_op  <= cmd_op;
      base     <= nxt_base;
      cnt      <= nxt_cnt;
      bw_lat   <= nxt_bw;
      s1       <= beat;
      s2       <= s1;
      wb_valid <= (s2.op == WRITE);
      wb_addr  <= s2.addr[ADDR_W-1:0];
      wb_data  <= Dq_i;
      wb_lane  <= wr_lane;
      rd_valid <= (s2.op == READ);
      if (s2.op == READ) Dq_o <= merged;
    end
  end

  ntram_array #(
    .ADDR_W (ADDR_W),
    .BYTES  (BYTES),
    .BYTE_W (BYTE_W),
    .DW     (DW)
  ) u_array (
    .clk   (CLK),
    .we    (wr_en),
    .wen   (wr_lane),
    .waddr (s2.addr[ADDR_W-1:0]),
    .wdata (Dq_i),
    .re    (en),
    .raddr (s1.addr[ADDR_W-1:0]),
    .rdata (rdata)
  );

endmodule
